// File: rtl/motors_pwm_capture_if.sv
// Measurement port bundle: PWM pin in, high/period/duty results and status pulses out.
// master = capture block; slave = pin driver plus telemetry consumer.
interface motors_pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             pwm_in;
    logic [CNT_W-1:0] high_count;
    logic [CNT_W-1:0] period_count;
    logic [5:0]       duty_out;
    logic             valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             overrun;

    modport master (
        input  pwm_in,
        output high_count, period_count, duty_out, valid,
        output stuck_high, stuck_low, overrun
    );

    modport slave (
        output pwm_in,
        input  high_count, period_count, duty_out, valid,
        input  stuck_high, stuck_low, overrun
    );
endinterface

// File: rtl/motors_pwm_capture.sv
// PWM capture: high time, period and 0..63 duty; results 8 clk after the latching rise (edge seen 3 clk after pin).
// No backpressure: valid/overrun are one-cycle pulses; optional PWM_CAP_GLITCH_FILTER_EN adds a FILT_LEN-sample filter.
module motors_pwm_capture #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 4096,
    parameter int FILT_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    motors_pwm_capture_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    if (FILT_LEN < 1 || (TIMEOUT >> CNT_W) != 0) begin : g_param_chk
        $error("motors_pwm_capture: FILT_LEN must be >= 1 and TIMEOUT < 2**CNT_W");
    end

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_nxt;

    logic sync1, sync2, lvl, lvl_d, rise, fall, edge_det;
    logic [CNT_W-1:0] hcnt, lcnt, idle_cnt, per_sat, hold_hi, div_dvs;
    logic [CNT_W:0]   psum, div_rem, div_sub, div_keep;
    logic [6:0]       div_q;
    logic [2:0]       div_cnt;
    logic             div_busy, div_ge, div_done, latch, timeout, stuck;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] filt_cnt;
    logic          filt_q;

    // Output follows the synchroniser only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= '0;
            filt_q   <= 1'b0;
        end else if (sync2 == filt_q) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            filt_q   <= sync2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end
    assign lvl = filt_q;
`else
    assign lvl = sync2;
`endif

    assign rise     = lvl & ~lvl_d;
    assign fall     = ~lvl & lvl_d;
    assign edge_det = rise | fall;
    assign stuck    = bus.stuck_high | bus.stuck_low;
    assign timeout  = !edge_det && !stuck && (idle_cnt == TO_VAL - 1'b1);

    assign psum    = {1'b0, hcnt} + {1'b0, lcnt};
    assign per_sat = psum[CNT_W] ? CNT_MAX : psum[CNT_W-1:0];

    // One quotient bit per cycle; remainder stays below twice the divisor
    assign div_sub  = div_rem - {1'b0, div_dvs};
    assign div_ge   = div_rem >= {1'b0, div_dvs};
    assign div_keep = div_ge ? div_sub : div_rem;
    assign div_done = div_busy && (div_cnt == 3'd7) && !timeout;

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE:    if (rise) state_nxt = HIGH;
            HIGH:    if (fall) state_nxt = LOW;
            LOW:     if (rise) begin
                         state_nxt = HIGH;
                         latch     = 1'b1;
                     end
            default: state_nxt = IDLE;
        endcase
        if (timeout) begin
            state_nxt = IDLE;
            latch     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lvl_d    <= 1'b0;
            hcnt     <= '0;
            lcnt     <= '0;
            idle_cnt <= '0;
        end else begin
            state <= state_nxt;
            lvl_d <= lvl;
            if (edge_det)   idle_cnt <= '0;
            else if (!stuck) idle_cnt <= idle_cnt + 1'b1;
            if ((state == IDLE || state == LOW) && rise) begin
                hcnt <= CNT_W'(1);
                lcnt <= '0;
            end else if (state == HIGH && fall) begin
                lcnt <= CNT_W'(1);
            end else if (state == HIGH) begin
                hcnt <= sat_inc(hcnt);
            end else if (state == LOW) begin
                lcnt <= sat_inc(lcnt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0;
            div_cnt  <= '0;
            div_rem  <= '0;
            div_dvs  <= '0;
            div_q    <= '0;
            hold_hi  <= '0;
        end else if (timeout) begin
            div_busy <= 1'b0;
        end else if (latch) begin
            div_busy <= 1'b1;
            div_cnt  <= '0;
            div_rem  <= {1'b0, hcnt};
            div_dvs  <= per_sat;
            div_q    <= '0;
            hold_hi  <= hcnt;
        end else if (div_busy && div_cnt != 3'd7) begin
            div_rem  <= div_keep << 1;
            div_q    <= {div_q[5:0], div_ge};
            div_cnt  <= div_cnt + 1'b1;
        end else if (div_done) begin
            div_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.high_count   <= '0;
            bus.period_count <= '0;
            bus.duty_out     <= '0;
            bus.valid        <= 1'b0;
            bus.stuck_high   <= 1'b0;
            bus.stuck_low    <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            bus.valid   <= timeout | div_done;
            bus.overrun <= latch && div_busy && (div_cnt != 3'd7);
            if (timeout) begin
                bus.high_count   <= lvl ? TO_VAL : '0;
                bus.period_count <= TO_VAL;
                bus.duty_out     <= {6{lvl}};
            end else if (div_done) begin
                bus.high_count   <= hold_hi;
                bus.period_count <= div_dvs;
                bus.duty_out     <= div_q[6] ? 6'd63 : div_q[5:0];
            end
            if (edge_det) begin
                bus.stuck_high <= 1'b0;
                bus.stuck_low  <= 1'b0;
            end else if (timeout) begin
                bus.stuck_high <= lvl;
                bus.stuck_low  <= ~lvl;
            end
        end
    end
endmodule

// File: tb/tb_motors_pwm_capture.sv
// Directed bench for motors_pwm_capture: table of steady waveforms plus timeout, overrun, reset and glitch sequences.
// Pin is driven on falling edges; results are sampled away from the rising edge.
`timescale 1ns/1ps
module tb_motors_pwm_capture;
`ifdef PWM_CAP_GLITCH_FILTER_EN
    localparam int FILT = 3;
`else
    localparam int FILT = 0;
`endif
    localparam int LAT    = 3 + FILT;            // pin edge to FSM reaction
    localparam int RES    = LAT + 8;             // latching pin rise to valid
    localparam int MIN_HI = (FILT > 1) ? FILT : 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    motors_pwm_capture_if #(.CNT_W(16)) bus ();
    motors_pwm_capture #(.CNT_W(16), .TIMEOUT(4096), .FILT_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        int hi; int per; int exp_hi; int exp_per; int exp_duty;
    } vec_t;
    vec_t vecs[10];

    int checks = 0, errors = 0;
    int cyc = 0, valid_cnt = 0, ovr_cnt = 0, last_vcyc = 0, vinterval = 0;
    logic [15:0] last_hi = '0, last_per = '0;
    logic [5:0]  last_duty = '0;
    logic [5:0]  duty_log[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            vinterval = cyc - last_vcyc;
            last_vcyc = cyc;
            last_hi   = bus.high_count;
            last_per  = bus.period_count;
            last_duty = bus.duty_out;
            duty_log.push_back(bus.duty_out);
        end
        if (bus.overrun === 1'b1) ovr_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {bus.high_count, bus.period_count, bus.duty_out, bus.valid,
                   bus.stuck_high, bus.stuck_low, bus.overrun}, 64'd0);
    endtask

    task automatic hold(input logic v, input int n);
        bus.pwm_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_wave(input int hi, input int per, input int n);
        repeat (n) begin
            hold(1'b1, hi);
            hold(1'b0, per - hi);
        end
    endtask

    // One 32/64 period from IDLE, then the closing rise; reports stuck_low around the first rise
    task automatic idle_start(output logic pre, output logic post, output int vdelta,
                              output int lat, output logic [5:0] duty);
        int v0;
        v0   = valid_cnt;
        pre  = 1'bx;
        post = 1'bx;
        bus.pwm_in = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (i == LAT - 1) pre = bus.stuck_low;
            if (i == LAT)     post = bus.stuck_low;
        end
        hold(1'b0, 32);
        vdelta = valid_cnt - v0;
        bus.pwm_in = 1'b1;
        lat  = -1;
        duty = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                lat  = i;
                duty = bus.duty_out;
                break;
            end
        end
    endtask

    initial begin
        int n, v0, o0, vd, lat, n0;
        logic pre, post;
        logic [5:0] duty;

        vecs[0] = '{5, 20, 5, 20, 16};
        vecs[1] = '{32, 64, 32, 64, 32};
        vecs[2] = '{MIN_HI, 64, MIN_HI, 64, MIN_HI};
        vecs[3] = '{64 - MIN_HI, 64, 64 - MIN_HI, 64, 64 - MIN_HI};
        vecs[4] = '{16, 64, 16, 64, 16};
        vecs[5] = '{10, 30, 10, 30, 21};
        vecs[6] = '{6, 9, 6, 9, 42};
        vecs[7] = '{3, 8, 3, 8, 24};
        vecs[8] = '{100, 200, 100, 200, 32};
        vecs[9] = '{256 - MIN_HI, 256, 256 - MIN_HI, 256, 63};

        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");

        // Pin low from reset: single timeout report
        rst_n = 1'b1;
        n = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (bus.valid) begin n = i; break; end
        end
        chk("timeout_low_cycle", n, 4096);
        chk("timeout_low_flags", {bus.stuck_high, bus.stuck_low}, 2'b01);
        chk("timeout_low_duty", bus.duty_out, 0);
        chk("timeout_low_high", bus.high_count, 0);
        chk("timeout_low_period", bus.period_count, 4096);
        v0 = valid_cnt;
        hold(1'b0, 200);
        chk("timeout_no_repeat", valid_cnt - v0, 0);

        idle_start(pre, post, vd, lat, duty);
        chk("stuck_low_before_edge", pre, 1);
        chk("stuck_low_cleared", post, 0);
        chk("idle_partial_ignored", vd, 0);
        chk("first_valid_latency", lat, RES);
        chk("first_valid_duty", duty, 32);

        // Period 6: every rise after the first latch overruns
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_cnt;
        o0 = ovr_cnt;
        run_wave(3, 6, 6);
        chk("overrun_no_valid", valid_cnt - v0, 0);
        chk("overrun_count", ovr_cnt - o0, 4);
        hold(1'b0, 20);
        chk("overrun_tail_valid", valid_cnt - v0, 1);
        chk("overrun_tail_duty", last_duty, 32);

        o0 = ovr_cnt;
        for (int k = 0; k < 10; k++) begin
            run_wave(vecs[k].hi, vecs[k].per, 4);
            hold(1'b1, 16);
            chk($sformatf("vec%0d_high", k), last_hi, vecs[k].exp_hi);
            chk($sformatf("vec%0d_period", k), last_per, vecs[k].exp_per);
            chk($sformatf("vec%0d_duty", k), last_duty, vecs[k].exp_duty);
            chk($sformatf("vec%0d_interval", k), vinterval, vecs[k].per);
        end
        chk("table_no_overrun", ovr_cnt - o0, 0);

        // 2-clk low glitch inside the high phase of a 32/64 waveform
        run_wave(32, 64, 2);
        n0 = duty_log.size();
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 20);
        hold(1'b0, 32);
        run_wave(32, 64, 1);
        hold(1'b1, 16);
`ifdef PWM_CAP_GLITCH_FILTER_EN
        chk("glitch_valid_count", duty_log.size() - n0, 3);
        chk("glitch_duty_a", duty_log[n0 + 1], 32);
        chk("glitch_duty_b", duty_log[n0 + 2], 32);
`else
        chk("glitch_valid_count", duty_log.size() - n0, 4);
        chk("glitch_duty_a", duty_log[n0 + 1], 53);
        chk("glitch_duty_b", duty_log[n0 + 2], 24);
`endif

        // Pin held high after the last rise
        n = -1;
        for (int i = 1; i <= 4300; i++) begin
            @(negedge clk);
            if (bus.valid) begin n = i; break; end
        end
        chk("timeout_high_cycle", n, LAT + 4096 - 16);
        chk("timeout_high_flags", {bus.stuck_high, bus.stuck_low}, 2'b10);
        chk("timeout_high_high", bus.high_count, 4096);
        chk("timeout_high_period", bus.period_count, 4096);
        chk("timeout_high_duty", bus.duty_out, 63);
        hold(1'b0, LAT - 1);
        chk("stuck_high_before_fall", bus.stuck_high, 1);
        hold(1'b0, 1);
        chk("stuck_high_cleared", bus.stuck_high, 0);

        // Reset in the middle of a division
        hold(1'b0, 20);
        run_wave(32, 64, 1);
        hold(1'b1, 7);
        v0 = valid_cnt;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset_outputs");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 20);
        chk("mid_reset_no_valid", valid_cnt - v0, 0);
        chk_zero("mid_reset_after_release");
        idle_start(pre, post, vd, lat, duty);
        chk("restart_partial_ignored", vd, 0);
        chk("restart_latency", lat, RES);
        chk("restart_duty", duty, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/motors_pwm_capture.md
Name: motors_pwm_capture

Overview:
Measures an incoming motor PWM waveform (feedback or loop-back of the motor drive line) and recovers its high time, period and a 6-bit duty code on the same 0..63 scale the PWM generator consumes. A waveform with period 64 clk and high time D yields duty_out = D. Sits between the motor-side PWM pin and the control/telemetry logic.

Parameters:
CNT_W, 16, width of high/low/period counters
TIMEOUT, 4096, clk cycles without any edge before a stuck level is declared (must be < 2^CNT_W)
FILT_LEN, 3, consecutive equal samples required by the glitch filter (only with the optional feature)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  PWM waveform, asynchronous to clk
high_count  output  CNT_W  high cycles of last complete period
period_count  output  CNT_W  total cycles of last complete period
duty_out  output  6  floor(high_count*64/period_count), saturated to 63
valid  output  1  one-cycle pulse: all three results updated
stuck_high  output  1  no edge for TIMEOUT cycles, level high
stuck_low  output  1  no edge for TIMEOUT cycles, level low
overrun  output  1  one-cycle pulse: result dropped, divider restarted

Behaviour:
- Reset: all outputs 0, state IDLE, synchroniser flops 0, counters 0.
- pwm_in passes a 2-flop synchroniser; edge detect compares synced value with its registered copy. Rise/fall detected 3 clk after the pin edge.
- FSM IDLE: ignore partial period; on rise -> HIGH, hcnt=1, lcnt=0.
- HIGH: hcnt++ each cycle (saturate at all-ones); on fall -> LOW, lcnt=1.
- LOW: lcnt++ (saturate); on rise -> latch high_count=hcnt, period_count=hcnt+lcnt (saturating add), start divider, hcnt=1, lcnt=0, stay in measurement loop (-> HIGH).
- Divider: sequential restoring, dividend {hcnt,6'b0}, divisor period; 7 iteration cycles, result registered; duty_out and valid update on the 8th cycle after the latching rise. high_count/period_count/duty_out update together in that same cycle (hold latched values internally until then).
- Quotient > 63 saturates to 63; period_count 0 cannot occur (minimum 2).
- Rise while divider busy (period < 8 clk): abandon current division, start with new values, pulse overrun in that cycle; no valid for the dropped period.
- Timeout: idle counter cleared on every edge, increments otherwise; on reaching TIMEOUT: state -> IDLE, stuck_high or stuck_low = synced level, high_count = level ? TIMEOUT : 0, period_count = TIMEOUT, duty_out = level ? 63 : 0, valid pulses once (no repeat while stuck).
- Stuck flags clear on the next detected edge of either polarity; measurement restarts from IDLE (first complete period after that rise reports normally).
- Divider result and timeout in same cycle: timeout wins, division discarded, no overrun.
- Reset asserted mid-operation: immediate return to reset values, in-flight division lost, no valid.

Optional Feature:
PWM_CAP_GLITCH_FILTER_EN: defined -> after the synchroniser, a filter updates its output only after FILT_LEN consecutive identical samples; pulses shorter than FILT_LEN clk are invisible; edge detect latency becomes 3+FILT_LEN clk. Not defined -> synchroniser output feeds edge detect directly, FILT_LEN unused.

Test Plan:
- Period 64, high 32 repeated (generator-style, duty 32) -> after first complete period, valid every 64 clk, high_count=32, period_count=64, duty_out=32.
- Period 64, high 1 then high 63 -> duty_out 1, then 63; high 63/period 64 gives 63, not saturation artefact.
- pwm_in held low from reset, TIMEOUT=4096 -> single valid at 4096 clk after reset sync, stuck_low=1, duty_out=0; then 64/32 waveform -> stuck_low clears on first rise, duty_out=32 after one full period.
- Period 6 (high 3) -> overrun pulses every rise after the first latch, no valid; switch to period 20 high 5 -> valid, duty_out=16.
- rst_n low mid-division -> no valid, all outputs 0; measurement restarts from IDLE after release.
- With PWM_CAP_GLITCH_FILTER_EN, FILT_LEN=3: 2-clk low glitch inside high phase of 64/32 waveform -> duty_out stays 32; without macro same stimulus -> extra period measured, duty_out differs from 32.
